// File: rtl/lzx_74hc85.sv
// ============================================================================
//  Module   : lzx_74hc85
//  Purpose  : 4-bit magnitude comparator with cascade inputs, registered outputs
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lzx_74hc85 (
  input  logic clk,
  input  logic rst,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic IA_g,
  input  logic IA_e,
  input  logic IA_l,
  output logic QA_g,
  output logic QA_e,
  output logic QA_l
);

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       a_higher;
  logic       a_lower;
  logic       decided;
  logic       next_g;
  logic       next_e;
  logic       next_l;

  assign op_a = {A3, A2, A1, A0};
  assign op_b = {B3, B2, B1, B0};

  // The first differing bit pair, scanning from the MSB, settles the result.
  always_comb begin
    a_higher = 1'b0;
    a_lower  = 1'b0;
    decided  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (op_a[i] != op_b[i])) begin
        decided  = 1'b1;
        a_higher = op_a[i];
        a_lower  = op_b[i];
      end
    end
  end

  // On equality the cascade inputs decide, including the two illegal patterns.
  always_comb begin
    next_g = 1'b0;
    next_e = 1'b0;
    next_l = 1'b0;
    if (a_higher) begin
      next_g = 1'b1;
    end else if (a_lower) begin
      next_l = 1'b1;
    end else begin
      next_g = ~IA_l & ~IA_e;
      next_e = IA_e;
      next_l = ~IA_g & ~IA_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      QA_g <= 1'b0;
      QA_e <= 1'b0;
      QA_l <= 1'b0;
    end else begin
      QA_g <= next_g;
      QA_e <= next_e;
      QA_l <= next_l;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lzx_74hc85.sv
// ============================================================================
//  Module   : tb_lzx_74hc85
//  Purpose  : Self-checking bench for lzx_74hc85 against a behavioural model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lzx_74hc85;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] ia;      // {IA_g, IA_e, IA_l}
  logic       qg, qe, ql;
  int         n_tests;
  int         n_fail;

  lzx_74hc85 dut (
    .clk (clk),
    .rst (rst),
    .A3  (a[3]), .A2 (a[2]), .A1 (a[1]), .A0 (a[0]),
    .B3  (b[3]), .B2 (b[2]), .B1 (b[1]), .B0 (b[0]),
    .IA_g(ia[2]), .IA_e(ia[1]), .IA_l(ia[0]),
    .QA_g(qg), .QA_e(qe), .QA_l(ql)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {g,e,l} from integer compare plus the cascade truth table.
  function automatic logic [2:0] model(input int av, input int bv, input logic [2:0] c);
    logic cg, ce, cl;
    {cg, ce, cl} = c;
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b001;
    if (ce)      return 3'b010;
    if (cg && cl) return 3'b000;
    if (cg)      return 3'b100;
    if (cl)      return 3'b001;
    return 3'b101;
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got gel=%b expected gel=%b", tag, got, exp);
    end
  endtask

  // Drive inputs off-edge, capture on the next rising edge, sample 1 time unit later.
  task automatic apply(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [2:0] c);
    a  = av;
    b  = bv;
    ia = c;
    @(posedge clk);
    #1;
    check(tag, {qg, qe, ql}, model(int'(av), int'(bv), c));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a   = 4'b1111;
    b   = 4'b0000;
    ia  = 3'b010;
    #1;
    check("reset_initial", {qg, qe, ql}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {qg, qe, ql}, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", {qg, qe, ql}, 3'b100);

    // Cascade inputs must not matter when operands differ.
    apply("casc_ign_l", 4'b0000, 4'b1111, 3'b100);
    apply("casc_ign_g", 4'b1111, 4'b0000, 3'b001);

    // Deciding bit at each position.
    apply("ripple_b3_g", 4'b1000, 4'b0111, 3'b010);
    apply("ripple_b2_g", 4'b1100, 4'b1011, 3'b010);
    apply("ripple_b1_g", 4'b1110, 4'b1101, 3'b010);
    apply("ripple_b0_g", 4'b1111, 4'b1110, 3'b010);
    apply("ripple_b3_l", 4'b0111, 4'b1000, 3'b010);
    apply("ripple_b0_l", 4'b1110, 4'b1111, 3'b010);

    // Equality with every cascade decode case.
    apply("eq_ie",   4'b1010, 4'b1010, 3'b010);
    apply("eq_ig",   4'b1010, 4'b1010, 3'b100);
    apply("eq_il",   4'b1010, 4'b1010, 3'b001);
    apply("eq_igil", 4'b1010, 4'b1010, 3'b101);
    apply("eq_none", 4'b1010, 4'b1010, 3'b000);
    apply("eq_all",  4'b1010, 4'b1010, 3'b111);

    // Outputs hold between edges even when inputs change.
    apply("lat_setup", 4'b1000, 4'b0111, 3'b010);
    a = 4'b0001;
    b = 4'b0100;
    #2;
    check("lat_hold", {qg, qe, ql}, 3'b100);
    @(posedge clk);
    #1;
    check("lat_update", {qg, qe, ql}, 3'b001);

    // Asynchronous clear mid-operation, then resume.
    a = 4'b1111;
    b = 4'b0000;
    #1;
    rst = 1'b1;
    #1;
    check("async_clear", {qg, qe, ql}, 3'b000);
    @(posedge clk);
    #1;
    check("async_hold", {qg, qe, ql}, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("async_resume", {qg, qe, ql}, 3'b100);

    // Exhaustive operand sweep with cascade equal.
    for (int i = 0; i < 256; i++) begin
      apply("exhaustive", 4'(i >> 4), 4'(i & 15), 3'b010);
    end

    // Random operands and arbitrary cascade patterns.
    for (int k = 0; k < 300; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(15));
      rb = ($urandom_range(3) == 0) ? ra : 4'($urandom_range(15));
      apply("random", ra, rb, 3'($urandom_range(7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lzx_74hc85.md
Name: lzx_74hc85

Overview:
- 4-bit magnitude comparator with cascade inputs, following 74HC85 truth-table semantics.
- Compares A[3:0] against B[3:0] and reports greater / equal / less.
- When A equals B, the cascade inputs from a less-significant stage decide the result.
- Outputs are registered for use in a clocked datapath; slices can be chained (QA_* of one stage feeds IA_* of the next, more significant, stage).

Parameters:
- None. Width is fixed at 4 bits per slice.

Ports:
- clk  input  1  system clock; rising-edge active
- rst  input  1  asynchronous reset, active-high
- A3  input  1  operand A bit 3 (MSB)
- A2  input  1  operand A bit 2
- A1  input  1  operand A bit 1
- A0  input  1  operand A bit 0 (LSB)
- B3  input  1  operand B bit 3 (MSB)
- B2  input  1  operand B bit 2
- B1  input  1  operand B bit 1
- B0  input  1  operand B bit 0 (LSB)
- IA_g  input  1  cascade in: lower stage reports A>B
- IA_e  input  1  cascade in: lower stage reports A=B
- IA_l  input  1  cascade in: lower stage reports A<B
- QA_g  output  1  registered result A>B
- QA_e  output  1  registered result A=B
- QA_l  output  1  registered result A<B

Behaviour:
- Clocking and reset: one clock (clk) and one asynchronous, active-high reset (rst).
- While rst=1, QA_g=0, QA_e=0 and QA_l=0, immediately and independent of clk.
- The first capture happens on the first rising clk edge after rst deasserts.
- Operands: A={A3,A2,A1,A0} and B={B3,B2,B1,B0}, unsigned.
- Priority: MSB first. The first differing bit pair, scanning bit 3 down to bit 0, decides the result.
- Next-state, A>B (any bit position decides A higher): g=1, e=0, l=0. Cascade inputs are ignored.
- Next-state, A<B: g=0, e=0, l=1. Cascade inputs are ignored.
- Next-state, A==B: g = ~IA_l & ~IA_e; e = IA_e; l = ~IA_g & ~IA_e.
- Resulting A==B cascade decode:
  - IA_e=1, any IA_g/IA_l -> e=1, g=0, l=0.
  - IA_g=1, IA_e=0, IA_l=0 -> g=1 only.
  - IA_l=1, IA_e=0, IA_g=0 -> l=1 only.
  - IA_g=1, IA_l=1, IA_e=0 -> all 0.
  - All cascade inputs 0 -> g=1, l=1, e=0.
- Latency: next-state is computed combinationally from the current inputs and registered on each rising clk edge. Outputs reflect the inputs sampled at the previous edge (1-cycle latency).
- There is no enable; every edge captures.
- Outputs never glitch between edges.
- Invariant: with legal one-hot cascade inputs, exactly one output is high after reset.
- Reset mid-operation: asynchronous clear to 000 overrides any pending capture. Normal operation resumes at the next edge after release.
- Inputs must be stable around the rising edge. There is no synchronisation of A, B or IA_*.

Test Plan:
- Reset: assert rst with A=1111, B=0000 -> QA_g/QA_e/QA_l = 0/0/0 while asserted. After release plus one edge -> 1/0/0.
- Cascade ignored: IA=g (1,0,0), A=0000, B=1111 -> QA_l=1, others 0. Then IA=l (0,0,1), A=1111, B=0000 -> QA_g=1, others 0.
- Decision ripple with IA_e=1 (one result per edge):
  - 1000 vs 0111 -> g.
  - 1100 vs 1011 -> g.
  - 1110 vs 1101 -> g.
  - 1111 vs 1110 -> g.
  - 0111 vs 1000 -> l.
  - 1110 vs 1111 -> l.
- Equality: A=B=1010 with IA_e=1 -> QA_e=1 only.
  - IA=(1,0,0) -> QA_g=1 only.
  - IA=(0,0,1) -> QA_l=1 only.
  - IA=(1,0,1) -> 000.
  - IA=(0,0,0) -> g=1, l=1.
- Latency: change A/B between edges -> outputs update only at the next rising edge. Exhaustive 256 A/B pairs with IA_e=1 must match an integer compare model one cycle later.
